// File: rtl/c3lib_gray_wrptr_ctrl.sv
// c3lib_gray_wrptr_ctrl
// Write-side pointer controller for a dual-clock FIFO. It keeps the binary
// write pointer and a registered gray copy for export to the read domain. It
// decodes the synchronised gray read pointer into full, level and a sticky
// overflow flag.
// Optional feature macro: C3LIB_WRPTR_AFULL_EN adds a registered almost_full
// output, set when the post-push level reaches AFULL_THRESH.
module c3lib_gray_wrptr_ctrl #(
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_THRESH = 12,
   localparam int PW          = ADDR_WIDTH + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_req,
   output logic          push_ack,
   output logic          wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [PW-1:0] wr_ptr_gray,
   input  logic [PW-1:0] rd_ptr_gray_sync,
   output logic          full,
   output logic [PW-1:0] level,
   output logic          ovf_err
`ifdef C3LIB_WRPTR_AFULL_EN
   ,
   output logic          almost_full
`endif
);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return (b >> 1) ^ b;
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_next;
   logic [PW-1:0] rbin;
   logic [PW-1:0] rd_gray_full_pat;

   // Read-pointer decode, occupancy, full detection and push acceptance.
   always_comb begin
      rbin             = gray2bin(rd_ptr_gray_sync);
      level            = wbin - rbin;
      // Full when the write pointer is a whole lap ahead. In gray code that
      // means the two top bits are inverted and the rest are equal.
      rd_gray_full_pat = {~rd_ptr_gray_sync[PW-1:PW-2], rd_ptr_gray_sync[PW-3:0]};
      full             = (wr_ptr_gray == rd_gray_full_pat);
      push_ack         = push_req & ~full;
      wr_en            = push_ack;
      wr_addr          = wbin[ADDR_WIDTH-1:0];
      wbin_next        = wbin + PW'(1);
   end

   // The binary and gray pointers advance on the same edge, so the exported
   // gray value changes one bit at a time and comes straight from a flop.
   // A push refused while full sets the sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbin        <= '0;
         wr_ptr_gray <= '0;
         ovf_err     <= 1'b0;
      end else begin
         if (push_ack) begin
            wbin        <= wbin_next;
            wr_ptr_gray <= bin2gray(wbin_next);
         end
         if (push_req && full) begin
            ovf_err <= 1'b1;
         end
      end
   end

`ifdef C3LIB_WRPTR_AFULL_EN
   logic [PW-1:0] level_next;

   // Level as it will be after this cycle's push (if any).
   always_comb begin
      level_next = level + {{(PW-1){1'b0}}, push_ack};
   end

   // almost_full is registered, so it follows the post-push level one edge later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         almost_full <= 1'b0;
      end else begin
         almost_full <= (level_next >= PW'(AFULL_THRESH));
      end
   end
`else
   // The threshold has no function in this build.
   logic unused_afull_thresh;
   assign unused_afull_thresh = (AFULL_THRESH != 0);
`endif

endmodule
